// File: rtl/input_port_pkg.sv
// rtl/input_port_pkg.sv - shared constants and helpers for the input port bank
package input_port_pkg;

    localparam logic SEL_STATE  = 1'b0;
    localparam logic SEL_EVENTS = 1'b1;

    localparam int EDGE_PRESS   = 0;
    localparam int EDGE_RELEASE = 1;
    localparam int EDGE_BOTH    = 2;

    localparam int JOY_UP    = 0;
    localparam int JOY_DOWN  = 1;
    localparam int JOY_LEFT  = 2;
    localparam int JOY_RIGHT = 3;
    localparam int JOY_FIRE  = 4;

    // rise = debounced press accepted, fall = debounced release accepted
    function automatic logic edge_hit(input int mode, input logic rise, input logic fall);
        case (mode)
            EDGE_PRESS:   edge_hit = rise;
            EDGE_RELEASE: edge_hit = fall;
            default:      edge_hit = rise | fall;
        endcase
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - two-flop synchroniser, polarity fix and debounce for one input line
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic IDLE_LEVEL = (ACTIVE_LOW != 0);

    logic          sync1;
    logic          sync2;
    logic          synced;
    logic          accept;
    logic [CW-1:0] cnt;

    assign synced = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
    assign accept = (synced != stable) && (cnt == LAST);
    assign rise   = accept & synced;
    assign fall   = accept & ~synced;

    // Synchroniser resets to the idle pin level so reset release never looks like a press
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= IDLE_LEVEL;
            sync2  <= IDLE_LEVEL;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            if (synced == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= synced;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/input_port_bank.sv
// rtl/input_port_bank.sv - debounced joystick/button bank with sticky events and a read port
module input_port_bank
    import input_port_pkg::*;
#(
    parameter int NUM_CHANNELS    = 2,
    parameter int CHANNEL_BITS    = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACTIVE_LOW      = 1,
    parameter int EDGE_MODE       = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CHANNELS*CHANNEL_BITS-1:0] pins,
    output logic [NUM_CHANNELS*CHANNEL_BITS-1:0] state,
    input  logic                                 rd_en,
    input  logic [3:0]                           rd_addr,
    output logic [7:0]                           rd_data,
    output logic                                 irq
);

    localparam int NB = NUM_CHANNELS * CHANNEL_BITS;

    logic [NB-1:0] rise_v;
    logic [NB-1:0] fall_v;
    logic [NB-1:0] ev_set;
    logic [NB-1:0] ev_q;
    logic [NB-1:0] ev_next;
    logic [NB-1:0] clr_mask;
    logic [7:0]    rd_mux;
    logic [2:0]    rd_ch;

    assign rd_ch = rd_addr[3:1];

    for (genvar i = 0; i < NB; i++) begin : g_line
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .pin   (pins[i]),
            .stable(state[i]),
            .rise  (rise_v[i]),
            .fall  (fall_v[i])
        );
        assign ev_set[i] = edge_hit(EDGE_MODE, rise_v[i], fall_v[i]);
    end

    // Channels that do not exist never match, so out-of-range reads return 0 and clear nothing
    always_comb begin
        rd_mux   = 8'h00;
        clr_mask = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (rd_ch == 3'(c)) begin
                if (rd_addr[0] == SEL_EVENTS) begin
                    rd_mux = 8'(ev_q[c*CHANNEL_BITS +: CHANNEL_BITS]);
                    clr_mask[c*CHANNEL_BITS +: CHANNEL_BITS] = {CHANNEL_BITS{rd_en}};
                end else begin
                    rd_mux = 8'(state[c*CHANNEL_BITS +: CHANNEL_BITS]);
                end
            end
        end
    end

    // A bit that is set in the clearing cycle survives the clear
    assign ev_next = ev_set | (ev_q & ~clr_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            ev_q    <= '0;
            rd_data <= 8'h00;
            irq     <= 1'b0;
        end else begin
            ev_q <= ev_next;
            irq  <= |ev_q;
            if (rd_en) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_input_port_bank.sv
// tb/tb_input_port_bank.sv - directed self-checking bench for input_port_bank
module tb_input_port_bank;
    import input_port_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pins;
    logic [15:0] state;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        irq;

    int checks = 0;
    int errors = 0;

    input_port_bank #(
        .NUM_CHANNELS   (2),
        .CHANNEL_BITS   (8),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW     (1),
        .EDGE_MODE      (EDGE_BOTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pins   (pins),
        .state  (state),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [3:0] addr);
        rd_en   = 1'b1;
        rd_addr = addr;
        tick(1);
        rd_en   = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        pins    = 16'hFFFF;
        rd_en   = 1'b0;
        rd_addr = 4'h0;
        tick(3);
        reset = 1'b0;
        chk("reset_state", state, 16'h0000);
        chk("reset_irq", {15'd0, irq}, 16'd0);
        chk("reset_rd_data", {8'd0, rd_data}, 16'd0);

        // Idle pins: 20 back-to-back event reads of ch0 stay empty
        rd_en   = 1'b1;
        rd_addr = 4'h1;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            chk("idle_ev_read", {8'd0, rd_data}, 16'd0);
            chk("idle_irq", {15'd0, irq}, 16'd0);
        end
        rd_en = 1'b0;
        chk("idle_state", state, 16'h0000);

        // Press ch0 fire: the sampling edge is edge 1, state rises on edge 6
        pins[JOY_FIRE] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            chk("fire_not_yet", {15'd0, state[JOY_FIRE]}, 16'd0);
        end
        tick(1);
        chk("fire_state", state, 16'h0010);
        chk("fire_irq_lag", {15'd0, irq}, 16'd0);
        tick(1);
        chk("fire_irq", {15'd0, irq}, 16'd1);
        do_read(4'h1);
        chk("fire_ev", {8'd0, rd_data}, 16'h0010);
        chk("irq_clear_edge", {15'd0, irq}, 16'd1);
        do_read(4'h1);
        chk("fire_ev_cleared", {8'd0, rd_data}, 16'h0000);
        chk("irq_dropped", {15'd0, irq}, 16'd0);

        // Three-cycle glitch on ch1 bit0 is rejected
        pins[8] = 1'b0;
        tick(3);
        pins[8] = 1'b1;
        tick(10);
        chk("glitch_state", state, 16'h0010);
        chk("glitch_irq", {15'd0, irq}, 16'd0);
        do_read(4'h3);
        chk("glitch_ev_ch1", {8'd0, rd_data}, 16'h0000);

        // Release of fire latches an event in both-edge mode
        pins[JOY_FIRE] = 1'b1;
        tick(8);
        chk("release_state", state, 16'h0000);
        do_read(4'h1);
        chk("release_ev", {8'd0, rd_data}, 16'h0010);
        do_read(4'h1);
        chk("release_ev_cleared", {8'd0, rd_data}, 16'h0000);

        // Press then release ch0 bit2 before reading: one event bit
        pins[JOY_LEFT] = 1'b0;
        tick(8);
        pins[JOY_LEFT] = 1'b1;
        tick(8);
        do_read(4'h1);
        chk("left_both_ev", {8'd0, rd_data}, 16'h0004);
        do_read(4'h1);
        chk("left_once", {8'd0, rd_data}, 16'h0000);

        // bit1 event pending; bit2 press lands on the same edge as the clearing read
        pins[JOY_DOWN] = 1'b0;
        tick(8);
        pins[JOY_LEFT] = 1'b0;
        tick(5);
        do_read(4'h1);
        chk("race_read", {8'd0, rd_data}, 16'h0002);
        chk("race_state", state, 16'h0006);
        do_read(4'h1);
        chk("race_set_wins", {8'd0, rd_data}, 16'h0004);
        do_read(4'h1);
        chk("race_cleared", {8'd0, rd_data}, 16'h0000);

        // Hold bits 0 and 3, release bits 1 and 2
        pins[JOY_DOWN]  = 1'b1;
        pins[JOY_LEFT]  = 1'b1;
        pins[JOY_UP]    = 1'b0;
        pins[JOY_RIGHT] = 1'b0;
        tick(8);
        chk("held_state", state, 16'h0009);
        do_read(4'h0);
        chk("state_read", {8'd0, rd_data}, 16'h0009);
        do_read(4'hB);
        chk("oob_read", {8'd0, rd_data}, 16'h0000);
        tick(2);
        chk("rd_hold_oob", {8'd0, rd_data}, 16'h0000);
        chk("irq_pending", {15'd0, irq}, 16'd1);
        do_read(4'h1);
        chk("oob_no_clear", {8'd0, rd_data}, 16'h000F);
        tick(2);
        chk("rd_hold_ev", {8'd0, rd_data}, 16'h000F);
        do_read(4'h1);
        chk("ev_after_clear", {8'd0, rd_data}, 16'h0000);
        chk("irq_idle_again", {15'd0, irq}, 16'd0);

        // Reset at cnt=2 of a pending press on bit5 discards the count
        pins[5] = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("midreset_state", state, 16'h0000);
        chk("midreset_rd_data", {8'd0, rd_data}, 16'h0000);
        chk("midreset_irq", {15'd0, irq}, 16'd0);
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            chk("post_reset_wait", state, 16'h0000);
        end
        tick(1);
        chk("post_reset_accept", state, 16'h0029);
        tick(1);
        chk("post_reset_irq", {15'd0, irq}, 16'd1);
        do_read(4'h1);
        chk("post_reset_ev", {8'd0, rd_data}, 16'h0029);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
